// File: rtl/bb8051_fetch_seq.sv
// ----------------------------------------------------------------------------
// bb8051_fetch_seq
// Instruction fetch sequencer for the bb8051 core. It owns the program
// counter, reads 1-3 opcode bytes per instruction from the internal ROM,
// assembles them into op1/op2/op3 and presents the instruction to the
// decoder/execute stage through a valid/ready handshake. PC redirects
// (jumps, calls, returns) are applied on the acceptance cycle.
//
// Ports
//   clk, rst        core clock, asynchronous active-high reset
//   rom_rd          ROM read strobe (data returns on rom_data next cycle)
//   rom_addr        ROM read address (the pc register)
//   rom_data        ROM read data
//   op_len          instruction length from the decoder, looked up on op1_out
//   hold            freeze request; the sequencer parks before the next fetch
//   op1/2/3_out     assembled opcode bytes (unused bytes read as 00)
//   op_valid        assembled instruction available
//   op_ready        execute accepts the instruction
//   inst_pc         address of op1 of the presented instruction
//   pc_out          address of the byte following the instruction
//   pc_load         redirect request, honoured only on the handshake cycle
//   pc_load_val     redirect target
// ----------------------------------------------------------------------------
module bb8051_fetch_seq #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            rom_rd,
  output logic [PC_W-1:0] rom_addr,
  input  logic [7:0]      rom_data,
  input  logic [1:0]      op_len,
  input  logic            hold,
  output logic [7:0]      op1_out,
  output logic [7:0]      op2_out,
  output logic [7:0]      op3_out,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [PC_W-1:0] inst_pc,
  output logic [PC_W-1:0] pc_out,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_load_val
);

  typedef enum logic [3:0] {
    S_RST, S_F1, S_L1, S_LEN, S_F2, S_L2, S_F3, S_L3, S_ISSUE
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = 1;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;
  logic [7:0]      op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
  logic [1:0]      eff_len;

  // A length of 0 from the decoder means a single-byte instruction.
  assign eff_len = (op_len == 2'd0) ? 2'd1 : op_len;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RST;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default before the case, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:   state_d = S_F1;
      S_F1:    if (!hold) state_d = S_L1;
      S_L1:    state_d = S_LEN;
      S_LEN:   state_d = (eff_len == 2'd1) ? S_ISSUE : S_F2;
      S_F2:    state_d = S_L2;
      S_L2:    state_d = (eff_len == 2'd3) ? S_F3 : S_ISSUE;
      S_F3:    state_d = S_L3;
      S_L3:    state_d = S_ISSUE;
      S_ISSUE: if (op_ready) state_d = S_F1;
      default: state_d = S_RST;
    endcase
  end

  // Decoded outputs: the read strobe and valid come straight from the state.
  always_comb begin
    rom_rd   = 1'b0;
    op_valid = 1'b0;
    unique case (state_q)
      S_F1:         rom_rd   = !hold;
      S_F2, S_F3:   rom_rd   = 1'b1;
      S_ISSUE:      op_valid = 1'b1;
      default:      ;
    endcase
  end

  // Datapath next-state. The pc advances as each byte lands, so in ISSUE it
  // already points past the instruction; wrap-around is plain PC_W-bit math.
  always_comb begin
    pc_d      = pc_q;
    inst_pc_d = inst_pc_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    op3_d     = op3_q;
    unique case (state_q)
      S_F1: if (!hold) inst_pc_d = pc_q;
      S_L1: begin
        op1_d = rom_data;
        op2_d = 8'h00;
        op3_d = 8'h00;
        pc_d  = pc_q + PC_ONE;
      end
      S_L2: begin
        op2_d = rom_data;
        pc_d  = pc_q + PC_ONE;
      end
      S_L3: begin
        op3_d = rom_data;
        pc_d  = pc_q + PC_ONE;
      end
      S_ISSUE: if (op_ready && pc_load) pc_d = pc_load_val;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      inst_pc_q <= RESET_PC;
      op1_q     <= 8'h00;
      op2_q     <= 8'h00;
      op3_q     <= 8'h00;
    end else begin
      pc_q      <= pc_d;
      inst_pc_q <= inst_pc_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      op3_q     <= op3_d;
    end
  end

  assign rom_addr = pc_q;
  assign pc_out   = pc_q;
  assign inst_pc  = inst_pc_q;
  assign op1_out  = op1_q;
  assign op2_out  = op2_q;
  assign op3_out  = op3_q;

endmodule

// File: tb/tb_bb8051_fetch_seq.sv
// ----------------------------------------------------------------------------
// tb_bb8051_fetch_seq
// Self-checking bench for bb8051_fetch_seq. A 64 KiB ROM image and an
// opcode-length table are filled with random data; a transaction-level model
// tracks the program counter and predicts, per instruction, the bytes, the
// addresses, the fetch count and the latency. A second instance with
// RESET_PC=FFFF covers address wrap-around straight out of reset.
// ----------------------------------------------------------------------------
module tb_bb8051_fetch_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_rd;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [1:0]  op_len;
  logic        hold = 1'b0;
  logic [7:0]  op1_out, op2_out, op3_out;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [15:0] inst_pc, pc_out;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0000;

  // Wrap-around instance signals.
  logic        rst_w = 1'b1;
  logic        rom_rd_w;
  logic [15:0] rom_addr_w;
  logic [7:0]  rom_data_w;
  logic [1:0]  op_len_w;
  logic        hold_w = 1'b0;
  logic [7:0]  op1_w, op2_w, op3_w;
  logic        op_valid_w;
  logic        op_ready_w = 1'b1;
  logic [15:0] inst_pc_w, pc_out_w;
  logic        pc_load_w = 1'b0;
  logic [15:0] pc_load_val_w = 16'h0000;

  logic [7:0]  mem     [65536];
  logic [1:0]  len_tab [256];
  logic [15:0] m_pc;
  int          rd_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  bb8051_fetch_seq u_dut (
    .clk(clk), .rst(rst), .rom_rd(rom_rd), .rom_addr(rom_addr),
    .rom_data(rom_data), .op_len(op_len), .hold(hold),
    .op1_out(op1_out), .op2_out(op2_out), .op3_out(op3_out),
    .op_valid(op_valid), .op_ready(op_ready), .inst_pc(inst_pc),
    .pc_out(pc_out), .pc_load(pc_load), .pc_load_val(pc_load_val)
  );

  bb8051_fetch_seq #(.PC_W(16), .RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst_w), .rom_rd(rom_rd_w), .rom_addr(rom_addr_w),
    .rom_data(rom_data_w), .op_len(op_len_w), .hold(hold_w),
    .op1_out(op1_w), .op2_out(op2_w), .op3_out(op3_w),
    .op_valid(op_valid_w), .op_ready(op_ready_w), .inst_pc(inst_pc_w),
    .pc_out(pc_out_w), .pc_load(pc_load_w), .pc_load_val(pc_load_val_w)
  );

  // Decoder stand-in: length looked up combinationally from op1.
  assign op_len   = len_tab[op1_out];
  assign op_len_w = len_tab[op1_w];

  // ROM: one-cycle read latency; garbage when not strobed.
  always @(posedge clk) begin
    rom_data <= rom_rd ? mem[rom_addr] : 8'($urandom);
    if (rom_rd === 1'b1) rd_cnt <= rd_cnt + 1;
  end

  function automatic logic [7:0] wrap_rom(input logic [15:0] a);
    case (a)
      16'hFFFF: return 8'h02;
      16'h0000: return 8'hA5;
      16'h0001: return 8'h5A;
      default:  return 8'hEE;
    endcase
  endfunction

  always @(posedge clk)
    rom_data_w <= rom_rd_w ? wrap_rom(rom_addr_w) : 8'($urandom);

  function automatic int eff(input logic [1:0] l);
    return (l == 2'd0) ? 1 : int'(l);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; op_ready = 1'b0; pc_load = 1'b0; hold = 1'b0;
    #1;
    check("rst_valid",   op_valid, 0);
    check("rst_rom_rd",  rom_rd,   0);
    check("rst_op1",     op1_out,  0);
    check("rst_op2",     op2_out,  0);
    check("rst_op3",     op3_out,  0);
    check("rst_inst_pc", inst_pc,  0);
    check("rst_pc",      rom_addr, 0);
    check("rst_pc_out",  pc_out,   0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_release_rd", rom_rd, 0);
    m_pc = 16'h0000;
  endtask

  // Park in F1 with hold asserted for n cycles, then release.
  task automatic park(input int n);
    hold = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("park_rd", rom_rd, 0);
      check("park_pc", rom_addr, m_pc);
    end
    hold = 1'b0;
    #1;
    check("hold_release", rom_rd, 1);
  endtask

  // One instruction end to end: fetch start, latency, content, stall, accept.
  task automatic run_inst(input int rdly, input bit load, input logic [15:0] lval);
    int w, lat, len, c0;
    logic [7:0]  b1, b2, b3;
    logic [15:0] npc, tgt;
    hold = 1'b0;
    w = 0;
    while (rom_rd !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    check("f1_reached", rom_rd, 1);
    check("fetch_addr", rom_addr, m_pc);
    b1  = mem[m_pc];
    len = eff(len_tab[b1]);
    b2  = (len >= 2) ? mem[16'(m_pc + 16'd1)] : 8'h00;
    b3  = (len == 3) ? mem[16'(m_pc + 16'd2)] : 8'h00;
    npc = 16'(m_pc + 16'(len));
    tgt = load ? lval : npc;
    c0  = rd_cnt;
    if (rdly == 0) begin
      op_ready = 1'b1; pc_load = load; pc_load_val = lval;
    end else begin
      // Junk on ready/redirect while nothing is valid must be ignored.
      op_ready = 1'($urandom); pc_load = 1'b1; pc_load_val = 16'($urandom);
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (rdly > 0 && lat == 2 * len) op_ready = 1'b0;
    end while (op_valid !== 1'b1 && lat < 20);
    check("latency", lat, 2 * len + 1);
    check("op1", op1_out, b1);
    check("op2", op2_out, b2);
    check("op3", op3_out, b3);
    check("inst_pc", inst_pc, m_pc);
    check("pc_out", pc_out, npc);
    check("fetches", rd_cnt - c0, len);
    for (int i = 0; i < rdly; i++) begin
      hold = 1'($urandom);
      @(negedge clk);
      check("stall_valid", op_valid, 1);
      check("stall_bytes", {op1_out, op2_out, op3_out}, {b1, b2, b3});
      check("stall_rd", rom_rd, 0);
    end
    op_ready = 1'b1; pc_load = load; pc_load_val = lval;
    @(negedge clk);
    check("accepted", op_valid, 0);
    check("next_addr", rom_addr, tgt);
    check("f1_after_hs", rom_rd, !hold);
    m_pc = tgt;
    op_ready = 1'b0; pc_load = 1'b0;
    if (hold) park($urandom_range(1, 3));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdly;
    bit ld;
    logic [15:0] lv;
    int w;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) len_tab[i] = 2'($urandom);
    len_tab[8'h00] = 2'd1;
    len_tab[8'h02] = 2'd3;
    len_tab[8'h74] = 2'd2;

    // Single-byte NOP from the reset vector.
    mem[16'h0000] = 8'h00;
    do_reset();
    run_inst(0, 1'b0, 16'h0000);

    // 3-byte LJMP with a redirect on acceptance.
    mem[16'h0000] = 8'h02; mem[16'h0001] = 8'h12; mem[16'h0002] = 8'h34;
    do_reset();
    run_inst(0, 1'b1, 16'h1234);

    // 2-byte instruction held off by execute for several cycles.
    mem[16'h1234] = 8'h74; mem[16'h1235] = 8'h55;
    run_inst(5, 1'b0, 16'h0000);
    park(3);

    // Reset in the middle of a 3-byte fetch (L2).
    mem[m_pc] = 8'h02;
    repeat (4) @(negedge clk);
    check("in_l2_rd", rom_rd, 0);
    check("in_l2_valid", op_valid, 0);
    do_reset();
    run_inst(1, 1'b0, 16'h0000);

    // Randomized instruction stream with stalls, redirects and holds.
    for (int n = 0; n < 250; n++) begin
      rdly = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      ld   = ($urandom_range(0, 3) == 0);
      lv   = ($urandom_range(0, 7) == 0) ? 16'(16'hFFFF - $urandom_range(0, 2))
                                         : 16'($urandom);
      run_inst(rdly, ld, lv);
    end

    // Wrap-around from RESET_PC=FFFF: bytes at FFFF, 0000, 0001.
    @(negedge clk);
    rst_w = 1'b0;
    w = 0;
    while (op_valid_w !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    check("wrap_latency", w, 8);
    check("wrap_op1", op1_w, 8'h02);
    check("wrap_op2", op2_w, 8'hA5);
    check("wrap_op3", op3_w, 8'h5A);
    check("wrap_inst_pc", inst_pc_w, 16'hFFFF);
    check("wrap_pc_out", pc_out_w, 16'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
